// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU sequencer: widths, opcodes, ALU ops, FSM states.
package cpu_pkg;

    localparam int unsigned PC_W     = 8;
    localparam int unsigned DATA_W   = 4;
    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned OP_W     = 4;
    localparam int unsigned ALU_OP_W = 2;

    // Opcodes live in IR[15:12]
    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OP_W-1:0] OP_LDA  = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h3;
    localparam logic [OP_W-1:0] OP_AND  = 4'h4;
    localparam logic [OP_W-1:0] OP_JMP  = 4'h5;
    localparam logic [OP_W-1:0] OP_LDB  = 4'h6;
    localparam logic [OP_W-1:0] OP_JZ   = 4'h7;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_e;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Instruction-memory handshake and ALU operand/result bus of the sequencer.
// master: sequencer side (drives imem_req/imem_addr and ALU operands)
// slave : memory + ALU side (drives imem_ack/imem_data and alu_result)
interface cpu_sequencer_if;
    import cpu_pkg::*;

    logic                imem_req;
    logic [PC_W-1:0]     imem_addr;
    logic                imem_ack;
    logic [INSTR_W-1:0]  imem_data;
    logic [ALU_OP_W-1:0] alu_op;
    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [DATA_W-1:0]   alu_result;

    modport master (
        output imem_req, imem_addr, alu_op, alu_a, alu_b,
        input  imem_ack, imem_data, alu_result
    );

    modport slave (
        input  imem_req, imem_addr, alu_op, alu_a, alu_b,
        output imem_ack, imem_data, alu_result
    );

endinterface

// File: rtl/cpu_sequencer_instr_decoder.sv
// Combinational opcode decoder.
// opcode_i      : IR[15:12]
// alu_op_o      : ALU operation for EXEC
// is_*_o        : instruction class flags
// illegal_o     : opcode is not defined (executes as NOP)
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [OP_W-1:0]     opcode_i,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic                is_alu_o,
    output logic                is_load_a_o,
    output logic                is_load_b_o,
    output logic                is_jmp_o,
    output logic                is_jz_o,
    output logic                is_halt_o,
    output logic                illegal_o
);

    always_comb begin
        alu_op_o    = ALU_ADD;
        is_alu_o    = 1'b0;
        is_load_a_o = 1'b0;
        is_load_b_o = 1'b0;
        is_jmp_o    = 1'b0;
        is_jz_o     = 1'b0;
        is_halt_o   = 1'b0;
        illegal_o   = 1'b0;
        case (opcode_i)
            OP_NOP:  begin end
            OP_ADD:  begin is_alu_o = 1'b1; alu_op_o = ALU_ADD; end
            OP_SUB:  begin is_alu_o = 1'b1; alu_op_o = ALU_SUB; end
            OP_AND:  begin is_alu_o = 1'b1; alu_op_o = ALU_AND; end
            OP_LDA:  is_load_a_o = 1'b1;
            OP_LDB:  is_load_b_o = 1'b1;
            OP_JMP:  is_jmp_o    = 1'b1;
            OP_JZ:   is_jz_o     = 1'b1;
            OP_HALT: is_halt_o   = 1'b1;
            default: illegal_o   = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// FETCH/DECODE/EXEC control sequencer for the 4-bit CPU datapath.
// clk, reset (async, active-low), start (leave IDLE/HALT)
// bus     : instruction fetch handshake + external ALU operands/result
// pc_out, acc_out, zero : architectural state
// halted, busy, ill_op  : status (ill_op pulses for the DECODE cycle of an undefined opcode)
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_A = 4'b0100,
    parameter logic [DATA_W-1:0] RESET_B = 4'b0001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    cpu_sequencer_if.master   bus,
    output logic [PC_W-1:0]   pc_out,
    output logic [DATA_W-1:0] acc_out,
    output logic              zero,
    output logic              halted,
    output logic              busy,
    output logic              ill_op
);

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]    a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic                 z_q, z_d;

    logic [ALU_OP_W-1:0]  dec_alu_op;
    logic                 dec_alu, dec_lda, dec_ldb, dec_jmp, dec_jz, dec_halt, dec_ill;
    logic [ALU_OP_W-1:0]  alu_op_c;
    logic [DATA_W-1:0]    alu_a_c, alu_b_c;
    logic                 unused_ir_bits;

    // IR[11:8] carries no information for any instruction
    assign unused_ir_bits = ^ir_q[11:8];

    instr_decoder u_dec (
        .opcode_i    (ir_q[15:12]),
        .alu_op_o    (dec_alu_op),
        .is_alu_o    (dec_alu),
        .is_load_a_o (dec_lda),
        .is_load_b_o (dec_ldb),
        .is_jmp_o    (dec_jmp),
        .is_jz_o     (dec_jz),
        .is_halt_o   (dec_halt),
        .illegal_o   (dec_ill)
    );

    // State and architectural registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= RESET_A;
            b_q     <= RESET_B;
            acc_q   <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            z_q     <= z_d;
        end
    end

    // Next state, register updates and EXEC-only ALU drive
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        z_d      = z_q;
        alu_op_c = '0;
        alu_a_c  = '0;
        alu_b_c  = '0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_FETCH;
                pc_d    = pc_q + PC_W'(1);
                if (dec_alu) begin
                    // PC advances on writeback in EXEC
                    state_d = S_EXEC;
                    pc_d    = pc_q;
                end else if (dec_halt) begin
                    state_d = S_HALT;
                end else if (dec_jmp || (dec_jz && z_q)) begin
                    pc_d = ir_q[PC_W-1:0];
                end
                if (dec_lda) a_d = ir_q[DATA_W-1:0];
                if (dec_ldb) b_d = ir_q[DATA_W-1:0];
            end
            S_EXEC: begin
                alu_op_c = dec_alu_op;
                alu_a_c  = (dec_alu_op == ALU_ADD) ? a_q : acc_q;
                alu_b_c  = b_q;
                acc_d    = bus.alu_result;
                z_d      = (bus.alu_result == '0);
                pc_d     = pc_q + PC_W'(1);
                state_d  = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    assign bus.imem_req  = (state_q == S_FETCH);
    assign bus.imem_addr = pc_q;
    assign bus.alu_op    = alu_op_c;
    assign bus.alu_a     = alu_a_c;
    assign bus.alu_b     = alu_b_c;
    assign pc_out        = pc_q;
    assign acc_out       = acc_q;
    assign zero          = z_q;
    assign halted        = (state_q == S_HALT);
    assign busy          = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
    assign ill_op        = (state_q == S_DECODE) && dec_ill;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboarded testbench for cpu_sequencer: an ISA-level reference model predicts
// every fetch (address, ACC, Z), the cycle count and the final state of each program.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] pc_out;
    logic [3:0] acc_out;
    logic       zero, halted, busy, ill_op;

    cpu_sequencer_if bus ();

    cpu_sequencer #(.RESET_A(4'b0100), .RESET_B(4'b0001)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bus     (bus),
        .pc_out  (pc_out),
        .acc_out (acc_out),
        .zero    (zero),
        .halted  (halted),
        .busy    (busy),
        .ill_op  (ill_op)
    );

    always #5 clk = ~clk;

    // Plain 4-bit ALU on the slave side
    always_comb begin
        case (bus.alu_op)
            2'b00:   bus.alu_result = bus.alu_a + bus.alu_b;
            2'b01:   bus.alu_result = bus.alu_a - bus.alu_b;
            2'b10:   bus.alu_result = bus.alu_a & bus.alu_b;
            default: bus.alu_result = 4'd0;
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction memory responder ----------------
    logic [15:0] mem [256];
    int  wait_q[$];
    bit  late_ack  = 1'b0;
    bit  req_seen  = 1'b0;
    int  wait_left = 0;

    initial begin
        bus.imem_ack  = 1'b0;
        bus.imem_data = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            if (late_ack) begin
                bus.imem_ack  = 1'b1;
                bus.imem_data = 16'h1000;
            end else if (bus.imem_req) begin
                if (!req_seen) begin
                    req_seen  = 1'b1;
                    wait_left = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
                end
                if (wait_left == 0) begin
                    bus.imem_ack  = 1'b1;
                    bus.imem_data = mem[bus.imem_addr];
                end else begin
                    bus.imem_ack  = 1'b0;
                    bus.imem_data = 16'($urandom);
                    wait_left--;
                end
            end else begin
                req_seen     = 1'b0;
                bus.imem_ack = 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0] addr;
        logic [3:0] acc;
        logic       z;
    } fetch_t;

    fetch_t exp_q[$];
    fetch_t mon_e;
    bit     mon_en   = 1'b1;
    int     ill_seen = 0;

    always @(negedge clk) begin
        if (ill_op) ill_seen++;
        if (mon_en && reset && bus.imem_req && bus.imem_ack) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected fetch: got addr %0h, expected no fetch", bus.imem_addr);
            end else begin
                mon_e = exp_q.pop_front();
                chk("fetch addr", bus.imem_addr, mon_e.addr);
                chk("fetch pc",   pc_out,        mon_e.addr);
                chk("fetch acc",  acc_out,       mon_e.acc);
                chk("fetch zero", zero,          mon_e.z);
            end
        end
    end

    // ---------------- ISA reference model ----------------
    logic [7:0] m_pc, s_pc;
    logic [3:0] m_a, m_b, m_acc, s_acc;
    logic       m_z;
    int         exp_cycles, exp_ill;

    task automatic model_reset();
        m_pc = 8'h00; m_a = 4'h4; m_b = 4'h1; m_acc = 4'h0; m_z = 1'b0;
    endtask

    // Execute from m_pc until HALT, queueing expected fetches and per-fetch waits
    task automatic model_run(input int max_wait, input int stall_idx, input int stall_len);
        logic [15:0] ir;
        int          w;
        bit          done;
        exp_cycles = 0; exp_ill = 0; done = 1'b0;
        s_pc = m_pc; s_acc = m_acc;
        for (int i = 0; i < 1000 && !done; i++) begin
            if (i == stall_idx)  w = stall_len;
            else if (max_wait > 0) w = int'($urandom_range(0, max_wait));
            else w = 0;
            wait_q.push_back(w);
            exp_q.push_back('{m_pc, m_acc, m_z});
            ir = mem[m_pc];
            exp_cycles += 2 + w;
            case (ir[15:12])
                4'h1: begin m_acc = m_a + m_b;   m_z = (m_acc == 4'h0); m_pc = m_pc + 8'd1; exp_cycles++; end
                4'h3: begin m_acc = m_acc - m_b; m_z = (m_acc == 4'h0); m_pc = m_pc + 8'd1; exp_cycles++; end
                4'h4: begin m_acc = m_acc & m_b; m_z = (m_acc == 4'h0); m_pc = m_pc + 8'd1; exp_cycles++; end
                4'h2: begin m_a = ir[3:0]; m_pc = m_pc + 8'd1; end
                4'h6: begin m_b = ir[3:0]; m_pc = m_pc + 8'd1; end
                4'h5: m_pc = ir[7:0];
                4'h7: m_pc = m_z ? ir[7:0] : m_pc + 8'd1;
                4'hF: begin m_pc = m_pc + 8'd1; done = 1'b1; end
                4'h0: m_pc = m_pc + 8'd1;
                default: begin m_pc = m_pc + 8'd1; exp_ill++; end
            endcase
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic fill_halt();
        for (int k = 0; k < 256; k++) mem[k] = 16'hF000;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        #2;
        chk("rst pc",       pc_out,       0);
        chk("rst acc",      acc_out,      0);
        chk("rst zero",     zero,         0);
        chk("rst halted",   halted,       0);
        chk("rst busy",     busy,         0);
        chk("rst ill_op",   ill_op,       0);
        chk("rst imem_req", bus.imem_req, 0);
        chk("rst alu_a",    bus.alu_a,    0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        wait_q.delete();
        model_reset();
    endtask

    // Pulse start, run to HALT and compare the end state with the model
    task automatic run_prog(input string tag, input int probes, input int pulse_at, output int cyc);
        int ill_base;
        ill_base = ill_seen;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!halted && cyc < 3000) begin
            if (cyc < probes) begin
                chk({tag, " stall req"},  bus.imem_req,  1);
                chk({tag, " stall addr"}, bus.imem_addr, s_pc);
                chk({tag, " stall pc"},   pc_out,        s_pc);
                chk({tag, " stall acc"},  acc_out,       s_acc);
            end
            start = (cyc == pulse_at);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk({tag, " halted"},  halted,         1);
        chk({tag, " busy"},    busy,           0);
        chk({tag, " cycles"},  cyc,            exp_cycles);
        chk({tag, " pc"},      pc_out,         m_pc);
        chk({tag, " acc"},     acc_out,        m_acc);
        chk({tag, " zero"},    zero,           m_z);
        chk({tag, " drained"}, exp_q.size(),   0);
        chk({tag, " ill_op"},  ill_seen - ill_base, exp_ill);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int cyc;
        int len;
        logic [3:0]  op;
        logic [15:0] ins;
        logic [31:0] rnd;

        #1;
        do_reset();

        // Small program: LDA 3, LDB 2, ADD, HALT
        fill_halt();
        mem[0] = 16'h2003; mem[1] = 16'h6002; mem[2] = 16'h1000; mem[3] = 16'hF000;
        model_run(0, -1, 0);
        run_prog("tp1", 0, -1, cyc);
        chk("tp1 cycles const", cyc, 9);
        chk("tp1 acc const", acc_out, 5);
        chk("tp1 pc const", pc_out, 8'h04);

        // SUB to zero then JZ taken to 0x10
        do_reset();
        fill_halt();
        mem[0] = 16'h2003; mem[1] = 16'h6002; mem[2] = 16'h1000;
        mem[3] = 16'h6005; mem[4] = 16'h3000; mem[5] = 16'h7010;
        model_run(0, -1, 0);
        run_prog("tp2", 0, -1, cyc);
        chk("tp2 zero const", zero, 1);
        chk("tp2 pc const", pc_out, 8'h11);

        // Three wait cycles on the first fetch
        do_reset();
        fill_halt();
        mem[0] = 16'h2007; mem[1] = 16'h1000; mem[2] = 16'hF000;
        model_run(0, 0, 3);
        run_prog("stall", 4, -1, cyc);
        chk("stall cycles const", cyc, 10);
        chk("stall acc const", acc_out, 8);

        // PC wrap through JMP 0xFF and JZ not taken at 0xFF, resuming from HALT
        do_reset();
        fill_halt();
        mem[8'h00] = 16'h50F0;
        model_run(0, -1, 0);
        run_prog("wrap0", 0, -1, cyc);
        mem[8'h00] = 16'hF000; mem[8'hF1] = 16'h50FF; mem[8'hFF] = 16'h0000;
        model_run(1, -1, 0);
        run_prog("wrap1", 0, -1, cyc);
        chk("wrap1 pc const", pc_out, 8'h01);
        mem[8'h01] = 16'h50FF; mem[8'hFF] = 16'h7010;
        model_run(1, -1, 0);
        run_prog("wrap2", 0, -1, cyc);
        chk("wrap2 pc const", pc_out, 8'h01);

        // Reset asserted during EXEC of ADD
        do_reset();
        fill_halt();
        mem[0] = 16'h1000;
        mon_en = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("exec busy",  busy,       1);
        chk("exec alu_a", bus.alu_a,  4);
        chk("exec alu_b", bus.alu_b,  1);
        chk("exec alu_op", bus.alu_op, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("mid-rst acc",  acc_out,      0);
        chk("mid-rst pc",   pc_out,       0);
        chk("mid-rst req",  bus.imem_req, 0);
        chk("mid-rst busy", busy,         0);
        chk("mid-rst alu_a", bus.alu_a,   0);
        @(posedge clk); #1;
        chk("mid-rst no wb", acc_out, 0);
        late_ack = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("late ack busy", busy, 0);
        chk("late ack req",  bus.imem_req, 0);
        @(posedge clk); #1;
        chk("late ack busy2", busy, 0);
        chk("late ack pc",    pc_out, 0);
        late_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Illegal opcode at 0x05, start pulsed while busy
        do_reset();
        fill_halt();
        mem[0] = 16'h2003; mem[1] = 16'h6002; mem[2] = 16'h1000; mem[3] = 16'h3000;
        mem[4] = 16'h0000; mem[5] = 16'h8123; mem[6] = 16'h1000; mem[7] = 16'hF000;
        model_run(0, -1, 0);
        run_prog("ill", 0, 3, cyc);
        chk("ill acc const", acc_out, 5);
        chk("ill pc const",  pc_out,  8'h08);

        // Random forward-jumping programs with random fetch latency
        for (int p = 0; p < 20; p++) begin
            do_reset();
            fill_halt();
            len = int'($urandom_range(6, 24));
            for (int k = 0; k < len; k++) begin
                op  = 4'($urandom_range(0, 15));
                rnd = $urandom;
                ins = {op, rnd[11:0]};
                if (op == 4'h5 || op == 4'h7) ins[7:0] = 8'($urandom_range(k + 1, len));
                mem[k] = ins;
            end
            model_run(3, -1, 0);
            run_prog("rand", 0, -1, cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
